// File: rtl/vga_pkg.sv
// Shared definitions for the VGA path: divider helpers and 640x480@60 timing.
package vga_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines.
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

    // The divider only supports even ratios of two or more (50 % duty).
    function automatic bit div_is_legal(input int div);
        return (div >= 2) && ((div % 2) == 0);
    endfunction

endpackage

// File: rtl/counter_vga.sv
// Pixel-clock generator: divides clk by an even ratio into a 50 % duty
// clk_vga, a one-cycle pixel-enable strobe on its rising edge, and a
// free-running divider bus.
module counter_vga
    import vga_pkg::*;
#(
    parameter int DIV   = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clk_vga,
    output logic             clk_vga_en,
    output logic [CNT_W-1:0] clkdiv
);

    localparam int HALF   = DIV / 2;
    localparam int HCNT_W = clog2_min1(HALF);
    localparam logic [HCNT_W-1:0] HCNT_TC = HCNT_W'(HALF - 1);

    // Reject unsupported ratios while elaborating rather than silently
    // producing a skewed duty cycle.
    generate
        if (!div_is_legal(DIV)) begin : g_bad_div
            $error("counter_vga: DIV must be even and at least 2");
        end
    endgenerate

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              clk_vga_q, clk_vga_d;
    logic              clk_vga_en_q, clk_vga_en_d;
    logic [CNT_W-1:0]  clkdiv_q, clkdiv_d;
    logic              hcnt_tc;

    assign hcnt_tc = (hcnt_q == HCNT_TC);

    // Next-state: half-period counter toggles clk_vga at terminal count;
    // the strobe fires only on the toggle that takes clk_vga high.
    always_comb begin
        hcnt_d       = hcnt_q + HCNT_W'(1);
        clk_vga_d    = clk_vga_q;
        clk_vga_en_d = 1'b0;
        clkdiv_d     = clkdiv_q + CNT_W'(1);
        if (hcnt_tc) begin
            hcnt_d       = '0;
            clk_vga_d    = ~clk_vga_q;
            clk_vga_en_d = ~clk_vga_q;
        end
    end

    // State registers; asynchronous reset truncates any phase in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q       <= '0;
            clk_vga_q    <= 1'b0;
            clk_vga_en_q <= 1'b0;
            clkdiv_q     <= '0;
        end else begin
            hcnt_q       <= hcnt_d;
            clk_vga_q    <= clk_vga_d;
            clk_vga_en_q <= clk_vga_en_d;
            clkdiv_q     <= clkdiv_d;
        end
    end

    assign clk_vga    = clk_vga_q;
    assign clk_vga_en = clk_vga_en_q;
    assign clkdiv     = clkdiv_q;

endmodule

// File: tb/tb_counter_vga.sv
// Bench for counter_vga: three instances (DIV=2, DIV=4, DIV=4 with a 4-bit
// divider bus) share clock and reset; expectations are queued per edge from
// a closed-form model and popped after the edge.
module tb_counter_vga;

    logic        clk;
    logic        rst_n;

    logic        v2, en2;
    logic [31:0] d2;
    logic        v4, en4;
    logic [31:0] d4;
    logic        vw, enw;
    logic [3:0]  dw;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int          e;
        logic        v2;
        logic        en2;
        logic [31:0] d2;
        logic        v4;
        logic        en4;
        logic [31:0] d4;
        logic        vw;
        logic [3:0]  dw;
    } exp_t;

    exp_t sb[$];

    counter_vga #(.DIV(2), .CNT_W(32)) u_div2 (
        .clk(clk), .rst_n(rst_n), .clk_vga(v2), .clk_vga_en(en2), .clkdiv(d2));
    counter_vga #(.DIV(4), .CNT_W(32)) u_div4 (
        .clk(clk), .rst_n(rst_n), .clk_vga(v4), .clk_vga_en(en4), .clkdiv(d4));
    counter_vga #(.DIV(4), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clk_vga(vw), .clk_vga_en(enw), .clkdiv(dw));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected outputs after edge e following reset release.
    function automatic exp_t model(input int e);
        exp_t x;
        x.e   = e;
        x.v2  = ((e / 1) % 2) == 1;
        x.en2 = (e % 2) == 1;
        x.d2  = 32'(e);
        x.v4  = ((e / 2) % 2) == 1;
        x.en4 = (e % 4) == 2;
        x.d4  = 32'(e);
        x.vw  = ((e / 2) % 2) == 1;
        x.dw  = 4'(e % 16);
        return x;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({v2, en2, v4, en4, vw, enw} !== 6'b0 || d2 !== 32'd0 || d4 !== 32'd0 || dw !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: v2=%b en2=%b d2=%0d v4=%b en4=%b d4=%0d vw=%b dw=%0d, required all 0",
                         i, v2, en2, d2, v4, en4, d4, vw, dw);
            end
        end
    endtask

    task automatic test_div2();
        exp_t x;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            edge_n++;
            sb.push_back(model(edge_n));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL div2 scoreboard empty");
            end else begin
                x = sb.pop_front();
                if (v2 !== x.v2 || en2 !== x.en2 || d2 !== x.d2) begin
                    errors++;
                    $display("FAIL div2 edge %0d: clk_vga=%b en=%b clkdiv=%0d, required %b %b %0d",
                             x.e, v2, en2, d2, x.v2, x.en2, x.d2);
                end
            end
        end
        checks++;
        if (d2 !== 32'd10) begin
            errors++;
            $display("FAIL div2_clkdiv_10: clkdiv=%0d, required 10", d2);
        end
    endtask

    task automatic test_div4();
        exp_t x;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            edge_n++;
            sb.push_back(model(edge_n));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL div4 scoreboard empty");
            end else begin
                x = sb.pop_front();
                if (v4 !== x.v4 || en4 !== x.en4 || d4 !== x.d4 || d4[1] !== v4) begin
                    errors++;
                    $display("FAIL div4 edge %0d: clk_vga=%b en=%b clkdiv=%0d, required %b %b %0d",
                             x.e, v4, en4, d4, x.v4, x.en4, x.d4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        do_reset();
        repeat (3) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v2, en2, v4, en4, vw, enw} !== 6'b0 || d2 !== 32'd0 || d4 !== 32'd0 || dw !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: v4=%b en4=%b d4=%0d v2=%b d2=%0d dw=%0d, required all 0",
                     v4, en4, d4, v2, d2, dw);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 8; i++) begin
            edge_n++;
            sb.push_back(model(edge_n));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL async_restart scoreboard empty");
            end else begin
                x = sb.pop_front();
                if (v4 !== x.v4 || en4 !== x.en4 || d4 !== x.d4) begin
                    errors++;
                    $display("FAIL async_restart edge %0d: clk_vga=%b en=%b clkdiv=%0d, required %b %b %0d",
                             x.e, v4, en4, d4, x.v4, x.en4, x.d4);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            edge_n++;
            sb.push_back(model(edge_n));
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wrap scoreboard empty");
            end else begin
                x = sb.pop_front();
                if (dw !== x.dw || vw !== x.vw || enw !== x.en4) begin
                    errors++;
                    $display("FAIL wrap edge %0d: clkdiv=%0d clk_vga=%b en=%b, required %0d %b %b",
                             x.e, dw, vw, enw, x.dw, x.vw, x.en4);
                end
            end
            if (edge_n == 15) begin
                checks++;
                if (dw !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_at_15: clkdiv=%0d, required 15", dw);
                end
            end
            if (edge_n == 16) begin
                checks++;
                if (dw !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_at_16: clkdiv=%0d, required 0", dw);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_div2();
        test_div4();
        test_async_reset();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
